// File: rtl/load_writeback_unit.sv
// Load/writeback unit: accepts one RV32I load, reads the word from memory with an
// ack/timeout handshake, extracts and extends the byte/half/word, then writes it back.
module load_writeback_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [2:0]      ld_funct3,
    input  logic [4:0]      ld_rd,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic            busy,
    output logic            misaligned,
    output logic            timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWb} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rf_data_q;
    logic [4:0]      rf_rd_q;
    logic            mis_q, to_q;

    logic            accept, ld_err, timed_out;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ext;

    assign ld_ready  = rst && (state_q == StIdle);
    assign accept    = ld_valid && ld_ready;
    // cnt_q holds the number of REQ cycles already completed before this one
    assign timed_out = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        ld_err = 1'b0;
        unique case (ld_funct3)
            3'b000, 3'b100: ld_err = 1'b0;
            3'b001, 3'b101: ld_err = ld_addr[0];
            3'b010:         ld_err = (ld_addr[1:0] != 2'b00);
            default:        ld_err = 1'b1;
        endcase
    end

    assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ext = mem_rdata;
        unique case (funct3_q)
            3'b000:  ext = {{(XLEN - 8){byte_sel[7]}}, byte_sel};
            3'b001:  ext = {{(XLEN - 16){half_sel[15]}}, half_sel};
            3'b100:  ext = {{(XLEN - 8){1'b0}}, byte_sel};
            3'b101:  ext = {{(XLEN - 16){1'b0}}, half_sel};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept && !ld_err) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CntW'(1);
                if (mem_ack) begin
                    state_d = StWb;
                end else if (timed_out) begin
                    state_d = StIdle;
                end
            end
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            rf_data_q <= '0;
            rf_rd_q   <= '0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= accept && ld_err;
            to_q    <= (state_q == StReq) && !mem_ack && timed_out;
            if (accept) begin
                addr_q   <= ld_addr;
                funct3_q <= ld_funct3;
                rd_q     <= ld_rd;
            end
            if ((state_q == StReq) && mem_ack) begin
                rf_data_q <= ext;
                rf_rd_q   <= rd_q;
            end
        end
    end

    assign busy       = (state_q != StIdle);
    assign mem_req    = (state_q == StReq);
    assign mem_addr   = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    // rd 0 still walks through WB but must never reach the register file
    assign rf_we      = (state_q == StWb) && (rd_q != 5'd0);
    assign rf_rd      = rf_rd_q;
    assign rf_data    = rf_data_q;
    assign misaligned = mis_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Self-checking bench for load_writeback_unit: per-cycle expectation table filled by a
// transaction-level model, randomized loads, plus literal checks on key scenarios.
module tb_load_writeback_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 16;
    localparam int          MAXC = 20000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [XLEN-1:0] ld_addr = '0;
    logic [2:0]      ld_funct3 = '0;
    logic [4:0]      ld_rd = '0;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;
    logic            busy, misaligned, timeout;

    load_writeback_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_funct3  (ld_funct3),
        .ld_rd      (ld_rd),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .busy       (busy),
        .misaligned (misaligned),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        bit          busy;
        bit          ready;
        bit          mis;
        bit          to;
    } exp_t;

    exp_t exp_tab [MAXC];
    exp_t e;

    int n_cmp = 0, n_fail = 0;
    int n_we = 0, n_req = 0, n_to = 0, n_mis = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_rd = '0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    task automatic clear_exp(input int from, input int n);
        for (int i = from; i < from + n && i < MAXC; i++) begin
            exp_tab[i] = '{req: 1'b0, addr: '0, we: 1'b0, rd: '0, data: '0,
                           busy: 1'b0, ready: 1'b1, mis: 1'b0, to: 1'b0};
        end
    endtask

    // Reference rules for a load
    function automatic bit model_err(input logic [31:0] a, input logic [2:0] f3);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if ((f3 == 1 || f3 == 5) && a[0]) return 1'b1;
        if (f3 == 2 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_ext(input logic [31:0] a, input logic [2:0] f3,
                                              input logic [31:0] w);
        logic [31:0] b, h, off;
        off = {30'd0, a[1:0]};
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst) begin
                check("rst_mem_req", {31'd0, mem_req}, 32'd0);
                check("rst_mem_addr", mem_addr, 32'd0);
                check("rst_rf_we", {31'd0, rf_we}, 32'd0);
                check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
                check("rst_rf_data", rf_data, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
                check("rst_pulses", {30'd0, misaligned, timeout}, 32'd0);
            end else if (cyc < MAXC) begin
                e = exp_tab[cyc];
                check("mem_req", {31'd0, mem_req}, {31'd0, e.req});
                if (e.req) check("mem_addr", mem_addr, e.addr);
                check("rf_we", {31'd0, rf_we}, {31'd0, e.we});
                if (e.we) begin
                    check("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
                    check("rf_data", rf_data, e.data);
                end
                check("busy", {31'd0, busy}, {31'd0, e.busy});
                check("ld_ready", {31'd0, ld_ready}, {31'd0, e.ready});
                check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                check("timeout", {31'd0, timeout}, {31'd0, e.to});
            end
        end
        if (rf_we) begin
            n_we++;
            last_data = rf_data;
            last_rd = rf_rd;
        end
        if (mem_req) n_req++;
        if (timeout) n_to++;
        if (misaligned) n_mis++;
    end

    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one load from an idle cycle; k = REQ cycle carrying the ack (0 = never ack).
    // Returns in an idle cycle.
    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] w, input int k);
        int acc, nreq;
        acc = cyc + 1;
        ld_valid = 1'b1;
        ld_addr = a;
        ld_funct3 = f3;
        ld_rd = rd;
        mem_ack = 1'b0;
        if (model_err(a, f3)) begin
            exp_tab[acc].mis = 1'b1;
            wait_cyc();
            ld_valid = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            return;
        end
        nreq = (k == 0) ? TO : k;
        for (int j = 0; j < nreq; j++) begin
            exp_tab[acc + j].req = 1'b1;
            exp_tab[acc + j].addr = {a[31:2], 2'b00};
            exp_tab[acc + j].busy = 1'b1;
            exp_tab[acc + j].ready = 1'b0;
        end
        if (k != 0) begin
            exp_tab[acc + k].we = (rd != 0);
            exp_tab[acc + k].rd = rd;
            exp_tab[acc + k].data = model_ext(a, f3, w);
            exp_tab[acc + k].busy = 1'b1;
            exp_tab[acc + k].ready = 1'b0;
        end else begin
            exp_tab[acc + TO].to = 1'b1;
        end
        wait_cyc();
        ld_valid = 1'b0;
        ld_addr = $urandom;
        ld_funct3 = 3'($urandom);
        ld_rd = 5'($urandom);
        for (int j = 1; j <= nreq; j++) begin
            mem_ack = (j == k);
            mem_rdata = (j == k) ? w : $urandom;
            wait_cyc();
        end
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (k != 0) wait_cyc();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [2:0]  f3;
        logic [31:0] res;
    } ext_case_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ext_case_t tbl [5];
        logic [31:0] ea [3];
        logic [2:0]  ef [3];
        int we0, req0, to0, mis0, a;
        tbl[0] = '{32'h103, 3'd0, 32'hFFFF_FF80};
        tbl[1] = '{32'h103, 3'd4, 32'h0000_0080};
        tbl[2] = '{32'h102, 3'd1, 32'hFFFF_80FF};
        tbl[3] = '{32'h102, 3'd5, 32'h0000_80FF};
        tbl[4] = '{32'h100, 3'd0, 32'h0000_0034};
        ea[0] = 32'h102; ef[0] = 3'd2;
        ea[1] = 32'h101; ef[1] = 3'd1;
        ea[2] = 32'h100; ef[2] = 3'd3;

        clear_exp(0, MAXC);
        chk_en = 1'b1;
        wait_cyc();
        wait_cyc();
        wait_cyc();
        rst = 1'b1;
        wait_cyc();

        // LW with immediate ack
        we0 = n_we;
        do_load(32'h100, 3'd2, 5'd5, 32'hDEAD_BEEF, 1);
        check("lw_data", last_data, 32'hDEAD_BEEF);
        check("lw_rd", {27'd0, last_rd}, 32'd5);
        check("lw_we_count", n_we - we0, 1);

        // Sub-word extraction
        for (int i = 0; i < 5; i++) begin
            do_load(tbl[i].a, tbl[i].f3, 5'd10 + 5'(i), 32'h80FF_1234, 1 + i % 3);
            check("ext_literal", last_data, tbl[i].res);
        end

        // Misaligned and illegal funct3
        for (int i = 0; i < 3; i++) begin
            we0 = n_we; req0 = n_req; mis0 = n_mis;
            do_load(ea[i], ef[i], 5'd3, 32'h1111_1111, 1);
            wait_cyc();
            check("mis_pulse_count", n_mis - mis0, 1);
            check("mis_no_req", n_req - req0, 0);
            check("mis_no_we", n_we - we0, 0);
        end

        // Timeout, then ack exactly on the last allowed cycle
        we0 = n_we; req0 = n_req; to0 = n_to;
        do_load(32'h140, 3'd2, 5'd6, 32'h5555_AAAA, 0);
        wait_cyc();
        check("to_req_cycles", n_req - req0, TO);
        check("to_pulse_count", n_to - to0, 1);
        check("to_no_we", n_we - we0, 0);
        we0 = n_we; req0 = n_req; to0 = n_to;
        do_load(32'h144, 3'd2, 5'd6, 32'h5555_AAAA, TO);
        check("ack_last_req_cycles", n_req - req0, TO);
        check("ack_last_no_to", n_to - to0, 0);
        check("ack_last_we", n_we - we0, 1);
        check("ack_last_data", last_data, 32'h5555_AAAA);

        // rd = 0 walks the full sequence without a write
        we0 = n_we; req0 = n_req;
        do_load(32'h200, 3'd2, 5'd0, 32'h1234_5678, 1);
        check("rd0_no_we", n_we - we0, 0);
        check("rd0_req", n_req - req0, 1);

        // Reset in the middle of REQ
        a = cyc + 1;
        ld_valid = 1'b1; ld_addr = 32'h300; ld_funct3 = 3'd2; ld_rd = 5'd7; mem_ack = 1'b0;
        for (int j = 0; j < 2; j++) begin
            exp_tab[a + j].req = 1'b1;
            exp_tab[a + j].addr = 32'h300;
            exp_tab[a + j].busy = 1'b1;
            exp_tab[a + j].ready = 1'b0;
        end
        wait_cyc();
        ld_valid = 1'b0;
        wait_cyc();
        rst = 1'b0;
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        clear_exp(cyc, 40);
        wait_cyc();
        wait_cyc();
        rst = 1'b1;
        we0 = n_we;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        wait_cyc();
        wait_cyc();
        wait_cyc();
        mem_ack = 1'b0;
        check("arst_stray_ack_no_we", n_we - we0, 0);
        do_load(32'h304, 3'd2, 5'd9, 32'hCAFE_F00D, 2);
        check("arst_fresh_data", last_data, 32'hCAFE_F00D);
        check("arst_fresh_rd", {27'd0, last_rd}, 32'd9);

        // Randomized loads
        for (int i = 0; i < 300 && cyc < MAXC - 60; i++) begin
            logic [31:0] ra;
            logic [2:0]  rf3;
            int rk;
            ra = 32'h0001_0000 + ($urandom & 32'h0000_0FFF);
            rf3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7))
                                               : 3'($urandom_range(0, 5));
            rk = $urandom_range(0, 19);
            if (rk > TO) rk = $urandom_range(1, 3);
            do_load(ra, rf3, 5'($urandom), $urandom, rk);
            if ($urandom_range(0, 3) == 0) wait_cyc();
        end
        wait_cyc();
        wait_cyc();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_writeback_unit.md
Name: load_writeback_unit

Overview:
- Sits between the multi-cycle control path, data memory and the register file write port (data_in/Rd/we).
- Accepts one load request, issues a word-aligned memory read, waits on an ack/timeout handshake, then byte/half-aligns and sign- or zero-extends the returned word.
- Writes the result to the register file with a single one-cycle write strobe.
- Handles all RV32I loads: LB, LH, LW, LBU, LHU.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 16, max cycles mem_req is held without mem_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
ld_valid  in  1  load request valid
ld_ready  out  1  unit can accept a request
ld_addr  in  XLEN  effective byte address
ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
ld_rd  in  5  destination register
mem_req  out  1  memory read request, held until ack/abort
mem_addr  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}
mem_ack  in  1  read data valid this cycle
mem_rdata  in  XLEN  read word
rf_we  out  1  register file write enable
rf_rd  out  5  register file write address
rf_data  out  XLEN  extended load result
busy  out  1  state != IDLE
misaligned  out  1  one-cycle pulse: misaligned or illegal funct3
timeout  out  1  one-cycle pulse: memory did not ack

Behaviour:
- Reset (rst low, async): state=IDLE; counter=0.
  - mem_req, mem_addr, rf_we, rf_rd, rf_data, misaligned, timeout, busy all 0.
  - ld_ready=0 while rst low; ld_ready=(state==IDLE) otherwise.
  - Reset mid-transaction drops mem_req immediately; no write, no pulse.
- States: IDLE, REQ, WB.
- IDLE:
  - Accept on rising edge where ld_valid && ld_ready; capture addr, funct3, rd.
  - Error check at accept:
    - LH/LHU with addr[0]=1.
    - LW with addr[1:0]!=0.
    - funct3 in {011,110,111}.
  - On error: misaligned=1 the next cycle only; stay IDLE; no mem_req; no write.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1 and mem_addr stable for every REQ cycle.
  - Counter increments each REQ cycle.
  - mem_ack high: capture mem_rdata, go to WB.
  - Else if the counter shows TIMEOUT REQ cycles elapsed: go to IDLE and pulse timeout=1 the next cycle.
  - mem_ack on the TIMEOUT-th cycle wins over timeout.
- WB (exactly one cycle):
  - rf_we=1, except rf_we=0 when rd==0; state still passes through WB.
  - rf_rd=rd; rf_data=extended value.
  - Next state IDLE.
  - rf_data/rf_rd hold their last value after WB; rf_we is 0 outside WB.
- mem_ack outside REQ is ignored. mem_req drops in the cycle after ack or abort.
- Extraction:
  - byte = rdata[8*addr[1:0]+7 : 8*addr[1:0]]
  - half = rdata[16*addr[1]+15 : 16*addr[1]]
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word unchanged.
- Latency: accept at edge T; REQ in cycle T+1; ack in that cycle gives WB in cycle T+2; ld_ready high again in cycle T+3.
- ld_ready is low in REQ and WB. There is no queueing: one outstanding load.

Test Plan:
- LW addr 0x0000_0100, rd=5, mem_rdata=0xDEADBEEF, ack in first REQ cycle -> mem_addr=0x100; rf_we for exactly 1 cycle with rf_rd=5, rf_data=0xDEADBEEF; ld_ready high 3 cycles after accept.
- mem_rdata=0x80FF_1234:
  - LB addr 0x103 -> rf_data 0xFFFF_FF80.
  - LBU addr 0x103 -> 0x0000_0080.
  - LH addr 0x102 -> 0xFFFF_80FF.
  - LHU addr 0x102 -> 0x0000_80FF.
  - LB addr 0x100 -> 0x0000_0034.
  - All cases: mem_addr=0x100.
- LW addr 0x102, LH addr 0x101, funct3=011 -> misaligned single-cycle pulse each; mem_req never asserted; rf_we stays 0; ld_ready returns next cycle.
- TIMEOUT=16:
  - No ack -> mem_req high exactly 16 cycles, then timeout pulse, no write, back to IDLE.
  - Repeat with ack on 16th cycle -> write occurs, timeout stays 0.
  - Stray ack in IDLE is ignored.
- LW rd=0, mem_rdata=0x1234_5678 -> full REQ/ack/WB sequence; rf_we stays 0; ld_ready returns at T+3.
- Drive rst low during REQ -> mem_req, busy 0 immediately; after release ld_ready=1; subsequent mem_ack produces no write; a fresh LW completes normally.
